// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard and forwarding-select generator that sits beside decode.
// Define SCOREBOARD_FWD_EN to enable forwarding; otherwise any in-flight producer stalls.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [FW-1:0]     fwd_a_sel,
    output logic [FW-1:0]     fwd_b_sel
);

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [DEPTH:1]    v_q, v_d;
    logic [DEPTH:1]    wen_q, wen_d;
    logic [DEPTH:1]    ld_q, ld_d;
    logic [REG_AW-1:0] rd_q [1:DEPTH];
    logic [REG_AW-1:0] rd_d [1:DEPTH];

    logic [FW:0] res_a, res_b;
    logic        accept;

    // Returns {hazard, select}; scanning old-to-young lets the youngest match win.
    function automatic logic [FW:0] lookup(input logic [REG_AW-1:0] src,
                                           input logic              used);
        logic          found;
        logic          ready;
        logic          is_ld;
        logic [FW-1:0] k_hit;
        found = 1'b0;
        is_ld = 1'b0;
        k_hit = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v_q[k] && wen_q[k] && rd_q[k] == src) begin
                found = 1'b1;
                k_hit = FW'(k);
                is_ld = ld_q[k];
            end
        end
        found = found & (src != '0) & used & id_valid;
        ready = FWD_EN & ~(is_ld & (int'(k_hit) < LOAD_STAGE));
        return {found & ~ready, (found & ready) ? k_hit : {FW{1'b0}}};
    endfunction

    always_comb begin
        res_a     = lookup(id_rs, id_rs_used);
        res_b     = lookup(id_rt, id_rt_used);
        stall     = (res_a[FW] | res_b[FW]) & ~flush;
        fwd_a_sel = res_a[FW-1:0];
        fwd_b_sel = res_b[FW-1:0];
    end

    assign accept = id_valid & ~stall & ~flush;

    always_comb begin
        v_d   = v_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!hold) begin
            v_d   = {v_q[DEPTH-1:1], accept};
            wen_d = {wen_q[DEPTH-1:1], accept & id_wen};
            ld_d  = {ld_q[DEPTH-1:1], accept & id_is_load};
            for (int k = DEPTH; k >= 2; k--) begin
                rd_d[k] = rd_q[k-1];
            end
            rd_d[1] = accept ? id_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            wen_q <= '0;
            ld_q  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            wen_q <= wen_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard scoreboard and forwarding controller for the pipelined MIPS core, generalising the fixed four-stage datapath, which has no interlocks. It sits beside the decode stage and keeps a shadow copy of the destination tag, write-enable and load flag for every in-flight instruction over DEPTH downstream stages. Each cycle it selects a forwarding source per decode operand, or requests a decode stall on a load-use hazard. Stage count, register-address width and load-data availability stage are parameters.

## Interface
- REG_AW, 5, register-address width
- DEPTH, 3, tracked stages after decode (1 = EX … DEPTH = WB), ≥2
- LOAD_STAGE, 2, first stage index where load data is forwardable, 1 < LOAD_STAGE ≤ DEPTH
- FW, $clog2(DEPTH+1), derived width of forward selects
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  REG_AW  source register addresses
- id_rs_used, id_rt_used  in  1  operand actually read
- id_rd  in  REG_AW  destination register
- id_wen  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is lw (result arrives at LOAD_STAGE)
- flush  in  1  squash decode instruction (taken branch)
- hold  in  1  global pipeline freeze (memory wait)
- stall  out  1  decode must hold; a bubble enters stage 1
- fwd_a_sel, fwd_b_sel  out  FW  0 = register file, k = result of stage k

## Operation
- Scoreboard: DEPTH entries {v, rd, wen, ld}; entry k mirrors pipeline stage k.
- Match(src, k) = v[k] & wen[k] & rd[k]==src & src!=0 & src_used & id_valid.
- Per operand, k* = smallest k with Match (youngest producer wins).
- No match: sel=0. Match with ld[k*] and k* < LOAD_STAGE: operand hazard, sel=0. Otherwise sel=k*.
- stall = (hazard on rs | hazard on rt) & ~flush.
- Update on each rising edge when hold=0:
  - entry[1] gets {1, id_rd, id_wen, id_is_load} if id_valid & ~stall & ~flush, else a bubble (v=0).
  - entry[k] gets entry[k-1] for k=2..DEPTH; entry[DEPTH] retires.
- hold=1: all entries retained; stall and selects are still evaluated from the current inputs.
- hold and flush together: hold wins. The requester keeps flush asserted until hold drops.
- rd=0 is never forwarded or stalled on; writes to r0 occupy an entry, but the entry never matches.

## Timing
- stall and fwd_*_sel are combinational from the ID inputs and registered entries, valid in the same cycle.
- Scoreboard latency: an instruction accepted at edge n appears in entry k after edge n+k-1, assuming no hold.
- Load-use with LOAD_STAGE=2: exactly 1 stall cycle, then sel=2.
- Reset (rst=0, asynchronous): all v=0, so stall=0 and fwd_a_sel=fwd_b_sel=0 immediately. rd, wen and ld are cleared to 0.
- Reset mid-operation discards all in-flight tags; the first post-reset decode sees no hazards.

## Configuration
- SCOREBOARD_FWD_EN defined: forwarding as described above.
- SCOREBOARD_FWD_EN undefined: no forwarding, so fwd_*_sel are tied to 0.
  - Any Match in any stage is a hazard and raises stall until the producer retires past DEPTH.
  - The register file must be write-before-read.

## Test plan
- Reset with rst=0 mid-stream, with lw r4 in entry 1 -> stall=0 and both sels 0 at once. After release, decode reading r4 -> sel 0, no stall.
- add r3 accepted, then decode rs=r3 on the following three cycles with bubbles between -> fwd_a_sel=1, 2, 3, then 0 after retirement.
- lw r4 then decode rt=r4 -> stall=1 for one cycle with a bubble in entry 1, then fwd_b_sel=2 and stall=0. Without SCOREBOARD_FWD_EN: stall=1 for 3 cycles, sel 0.
- add r7 then sub r7 back-to-back, then decode rs=r7,rt=r7 -> fwd_a_sel=fwd_b_sel=1 (youngest). Write to r0 followed by a read of r0 -> sel 0, no stall.
- lw r2 in entry 1, hold=1 for 3 cycles with consumer of r2 in decode -> stall=1 throughout, entries unchanged. After hold drops, one edge later sel=2.
- flush=1 with id_valid, id_rd=r9, id_wen=1 -> entry 1 is a bubble, and the next decode reading r9 gets sel 0. Assert flush together with a load-use hazard -> stall=0.
